// File: rtl/clock_display_driver.sv
// Time-bus to 8-digit multiplexed seven-segment driver: double-dabble BCD
// conversion of a snapshot, atomic commit, then a registered digit scan.
module clock_display_driver #(
  parameter int unsigned SCAN_DIV = 1,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic        clk_1khz,
  input  logic        reset_in,
  input  logic [26:0] digit,
  input  logic        switch,
  output logic [7:0]  an,
  output logic [6:0]  seg,
  output logic        dp
);

  localparam int unsigned BIN_W  = 10;
  localparam int unsigned BCD_W  = 12;
  localparam int unsigned STEP_W = BIN_W + BCD_W;
  localparam int unsigned DIV_W  = 8;
  localparam int unsigned CNT_W  = 4;

  typedef struct packed {
    logic [4:0] hr;
    logic [5:0] min;
    logic [5:0] sec;
    logic [9:0] ms;
  } time_t;

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_SHIFT, ST_COMMIT} state_t;

  time_t                     t;
  state_t                    state_q, state_d;
  logic [CNT_W-1:0]          shcnt_q, shcnt_d;
  logic [3:0][BIN_W-1:0]     bin_q, bin_d;    // [3]=hr [2]=min [1]=sec [0]=ms
  logic [3:0][BCD_W-1:0]     bcd_q, bcd_d;
  logic [3:0]                rng_q, rng_d;    // per-field out-of-range from snapshot
  logic [7:0][3:0]           nib_q, nib_d;
  logic [3:0]                dash_q, dash_d;
  logic [DIV_W-1:0]          div_q, div_d;
  logic [2:0]                idx_q, idx_d;
  logic [7:0]                an_q, an_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic [4:0]                hr_adj;
  logic                      hr_bad;
  logic [3:0]                cur_nib;

  assign t = time_t'(digit);

  // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
  function automatic logic [STEP_W-1:0] dd_step(input logic [STEP_W-1:0] v);
    logic [STEP_W-1:0] r;
    r = v;
    for (int n = 0; n < 3; n++) begin
      if (r[BIN_W + 4*n +: 4] >= 4'd5) r[BIN_W + 4*n +: 4] = r[BIN_W + 4*n +: 4] + 4'd3;
    end
    return r << 1;
  endfunction

  function automatic logic [6:0] font(input logic [3:0] n);
    case (n)
      4'd0:    font = 7'b1000000;
      4'd1:    font = 7'b1111001;
      4'd2:    font = 7'b0100100;
      4'd3:    font = 7'b0110000;
      4'd4:    font = 7'b0011001;
      4'd5:    font = 7'b0010010;
      4'd6:    font = 7'b0000010;
      4'd7:    font = 7'b1111000;
      4'd8:    font = 7'b0000000;
      4'd9:    font = 7'b0010000;
      default: font = 7'b1111111;
    endcase
  endfunction

  // Hour mapping for 12/24-hour display of the incoming snapshot.
  always_comb begin
    hr_adj = t.hr;
    hr_bad = 1'b0;
    if (switch) begin
      hr_bad = (t.hr > 5'd23);
    end else begin
      hr_bad = (t.hr > 5'd12);
      if (t.hr == 5'd0) hr_adj = 5'd12;
    end
  end

  // Conversion FSM next state.
  always_comb begin
    state_d = state_q;
    shcnt_d = shcnt_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    rng_d   = rng_q;
    nib_d   = nib_q;
    dash_d  = dash_q;
    case (state_q)
      ST_IDLE: state_d = ST_LOAD;
      ST_LOAD: begin
        bin_d[3] = BIN_W'(hr_adj);
        bin_d[2] = BIN_W'(t.min);
        bin_d[1] = BIN_W'(t.sec);
        bin_d[0] = t.ms;
        bcd_d    = '0;
        rng_d    = {hr_bad, (t.min > 6'd59), (t.sec > 6'd59), (t.ms > 10'd999)};
        shcnt_d  = '0;
        state_d  = ST_SHIFT;
      end
      ST_SHIFT: begin
        for (int f = 0; f < 4; f++) begin
          {bcd_d[f], bin_d[f]} = dd_step({bcd_q[f], bin_q[f]});
        end
        shcnt_d = shcnt_q + CNT_W'(1);
        if (shcnt_q == CNT_W'(BIN_W - 1)) state_d = ST_COMMIT;
      end
      ST_COMMIT: begin
        nib_d   = {bcd_q[3][7:4], bcd_q[3][3:0], bcd_q[2][7:4], bcd_q[2][3:0],
                   bcd_q[1][7:4], bcd_q[1][3:0], bcd_q[0][11:8], bcd_q[0][7:4]};
        dash_d  = rng_q;
        state_d = ST_LOAD;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Scan divider, digit index and registered pin values.
  always_comb begin
    div_d   = div_q + DIV_W'(1);
    idx_d   = idx_q;
    cur_nib = nib_q[idx_q];
    if (div_q >= DIV_W'(SCAN_DIV - 1)) begin
      div_d = '0;
      idx_d = idx_q - 3'd1;
    end
    an_d = ~(8'd1 << idx_q);
    if (dash_q[idx_q[2:1]]) begin
      seg_d = 7'b0111111;
    end else if ((BLANK_LZ != 0) && (idx_q == 3'd7) && (cur_nib == 4'd0)) begin
      seg_d = 7'h7F;
    end else begin
      seg_d = font(cur_nib);
    end
    dp_d = ~((idx_q == 3'd6) || (idx_q == 3'd4) || (idx_q == 3'd2));
  end

  always_ff @(posedge clk_1khz or negedge reset_in) begin
    if (!reset_in) begin
      state_q <= ST_IDLE;
      shcnt_q <= '0;
      bin_q   <= '0;
      bcd_q   <= '0;
      rng_q   <= '0;
      nib_q   <= '0;
      dash_q  <= '0;
      div_q   <= '0;
      idx_q   <= 3'd7;
      an_q    <= 8'hFF;
      seg_q   <= 7'h7F;
      dp_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      shcnt_q <= shcnt_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      rng_q   <= rng_d;
      nib_q   <= nib_d;
      dash_q  <= dash_d;
      div_q   <= div_d;
      idx_q   <= idx_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an  = an_q;
  assign seg = seg_q;
  assign dp  = dp_q;

endmodule

// File: doc/clock_display_driver.md
Name: clock_display_driver

Overview:
- Consumes the packed 27-bit time bus `digit` = {hr[4:0], min[5:0], sec[5:0], ms[9:0]} produced by the time-keeping counter.
- Converts each field to BCD with an iterative shift-add-3 (double-dabble) engine and holds the results in a committed display register set.
- Time-multiplexes eight active-low seven-segment digits showing HH.MM.SS.ms(hundreds, tens).
- Sits between the counter and the board display pins.

Parameters:
- SCAN_DIV, 1, clock cycles each digit stays lit; legal range 1..255.
- BLANK_LZ, 1, when 1, a zero hour-tens digit is blanked.

Ports:
- clk_1khz  input  1  system clock (1 kHz).
- reset_in  input  1  asynchronous, active-low reset.
- digit  input  27  packed time bus: [26:22] hr, [21:16] min, [15:10] sec, [9:0] ms.
- switch  input  1  1 = 24-hour display, 0 = 12-hour display.
- an  output  8  digit anodes, active-low; an[7] is the leftmost digit.
- seg  output  7  cathodes, active-low, ordered {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.

Behaviour:
- Reset (reset_in=0, asynchronous): an=8'hFF, seg=7'h7F, dp=1. All eight display nibbles=0, FSM=IDLE, scan index=7, divider=0, shift counter=0.
- FSM states: IDLE, LOAD, SHIFT, COMMIT.
  - IDLE→LOAD: unconditional, next cycle.
  - LOAD: snapshot `digit` and `switch`. Each field is zero-extended to 10 bits. BCD accumulators are cleared.
  - SHIFT: 10 cycles. Each cycle, every BCD nibble ≥5 gets +3, then the whole {bcd, bin} is shifted left by 1. All four fields convert in parallel.
  - COMMIT: one cycle. Display nibbles update atomically, then the FSM returns to LOAD.
  - Cycle timing: snapshot at cycle N, commit at N+11, next snapshot at N+12.
  - Displayed data is never a mix of two snapshots.
- Range check, evaluated on the snapshot:
  - hr>23, min>59 or sec>59: both digits of that field show a dash (7'b0111111).
  - ms>999: both ms digits show a dash.
- 12-hour mode (snapshot switch=0): hr==0 displays 12. hr>12 is out of range and shows dashes.
- Leading-zero blanking: if BLANK_LZ=1 and the hour-tens value is 0, that digit is blank (7'h7F).
- Digit map, index 7..0: H1, H0, M1, M0, S1, S0, ms-hundreds, ms-tens. The ms-units digit is not displayed.
- Scan:
  - The divider counts 0..SCAN_DIV-1. At terminal count the index decrements, wrapping 0→7.
  - an, seg and dp are registered. an = ~(1<<index).
  - seg = font(nibble[index]) using the standard 0–9 active-low font. Nibble codes 10..15 are not produced; if they occur, show blank.
  - dp=0 on indices 6, 4 and 2; otherwise 1.
  - With SCAN_DIV=1, one index per cycle gives a 125 Hz full refresh.
- Mid-conversion input changes are ignored until the next LOAD. A reset mid-SHIFT discards the partial result and returns every output to its reset value.
- A `switch` change takes effect at the next snapshot.

Test Plan:
- Reset: hold reset_in=0 while clocking → an=FF, seg=7F, dp=1. Release, then wait 12 cycles → first commit occurs. Assert reset mid-SHIFT → outputs return to reset values immediately, with no clock needed.
- Conversion, switch=1, BLANK_LZ=0: hr=13, min=45, sec=7, ms=987 held constant → index 7..0 shows 1,3,4,5,0,7,9,8. Check seg for 1 = 7'b1111001 and for 8 = 7'b0000000. dp=0 only when an=BF, EF or FB.
- Boundaries: hr=23, min=59, sec=59, ms=999 → 2,3,5,9,5,9,9,9. Then hr=24, min=60 → hour and minute digits show 7'b0111111; seconds and ms digits are unaffected.
- 12-hour mode: switch=0 with hr=0 → displays 1,2. With hr=13 → dashes. With BLANK_LZ=1 and hr=9 → an[7] slot shows seg=7F.
- Atomicity: change `digit` every cycle (counting ms) → each committed frame equals exactly the value sampled at its LOAD cycle. Commits are spaced 12 cycles apart.
- Scan: SCAN_DIV=3 → each an pattern is held for exactly 3 cycles, with sequence 7F, BF, DF, … FE, 7F.
